posit_encode_pipe: RTL

// - Pipelined posit packer: converts unpacked {sign, scale, normalized fraction, sticky} into a packed N-bit posit with RNE rounding.
// - Write-side counterpart to the posit field extractor; sits after the mantissa datapath of the posit arithmetic units.
// - Two register stages with valid/ready flow control, full throughput of 1 posit/cycle.

---
 rtl/posit_encode_pipe.sv | 92 +++++++++
 1 files changed

// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe: two-stage valid/ready packer of {sign, scale, fraction, sticky} into an RNE-rounded posit
module posit_encode_pipe #(
  parameter int N  = 16,
  parameter int es = 2,
  parameter int Bs = $clog2(N),
  parameter int SW = es + Bs + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic signed [SW-1:0] in_scale,
  input  logic [N-1:0]         in_frac,
  input  logic                 in_sticky,
  input  logic                 in_zero,
  input  logic                 in_inf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out,
  output logic                 out_zero,
  output logic                 out_inf
);
  localparam int KW  = SW - es;
  localparam int TW  = N + es + 1;
  localparam int WW  = TW + N;
  localparam int SAT = (N - 2) << es;
  localparam logic signed [SW-1:0] SAT_P = SW'(SAT);
  localparam logic signed [SW-1:0] SAT_N = -SAT_P;
  logic          s1_valid, s1_sign, s1_rb, s1_sticky, s1_zero, s1_inf, s1_max, s1_min, s1_adv;
  logic [KW-1:0] s1_sh, k;
  logic [es-1:0] s1_e;
  logic [N-2:0]  s1_frac, kept, mag;
  logic [WW-1:0] wide;
  logic [N-1:0]  sum, posit, nxt;
  logic          g, st, up;
  assign s1_adv   = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s1_adv;
  assign k        = in_scale[SW-1:es];
  // stage 1: split scale into regime shift and exponent, flag saturation, mask unused fraction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_rb     <= 1'b0;
      s1_sh     <= '0;
      s1_e      <= '0;
      s1_frac   <= '0;
      s1_sticky <= 1'b0;
      s1_zero   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_max    <= 1'b0;
      s1_min    <= 1'b0;
    end else if (in_ready) begin
      s1_valid  <= in_valid;
      s1_sign   <= in_sign;
      s1_rb     <= ~k[KW-1];
      s1_sh     <= k[KW-1] ? ~k : k;
      s1_e      <= in_scale[es-1:0];
      s1_frac   <= in_frac[N-2:0] & {(N-1){~(in_zero | in_inf)}};
      s1_sticky <= in_sticky & ~(in_zero | in_inf);
      s1_zero   <= in_zero | ~in_frac[N-1];
      s1_inf    <= in_inf;
      s1_max    <= in_scale >= SAT_P;
      s1_min    <= in_scale <= SAT_N;
    end
  // stage 2 datapath: regime fill by arithmetic shift, RNE round, clamp, negate, special cases
  always_comb begin
    wide  = WW'($signed({s1_rb, ~s1_rb, s1_e, s1_frac, {N{1'b0}}}) >>> s1_sh);
    kept  = wide[WW-1 -: N-1];
    g     = wide[WW-N];
    st    = |wide[WW-N-1:0] | s1_sticky;
    up    = g & (st | kept[0]);
    sum   = {1'b0, kept} + N'(up);
    mag   = (s1_max | sum[N-1]) ? {(N-1){1'b1}} : (s1_min | ~|sum) ? (N-1)'(1) : sum[N-2:0];
    posit = s1_sign ? -{1'b0, mag} : {1'b0, mag};
    nxt   = s1_inf ? {1'b1, {(N-1){1'b0}}} : s1_zero ? '0 : posit;
  end
  // stage 2 register: output word, held while downstream stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_zero  <= 1'b0;
      out_inf   <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      out       <= nxt;
      out_zero  <= ~s1_inf & s1_zero;
      out_inf   <= s1_inf;
    end
endmodule
